// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : Two-master (I-cache, D-cache) to one-slave cache-bus arbiter.
//               Forwards one master's burst at a time to the memory-side port.
//               The grant is locked from the first forwarded beat until the
//               slave accepts the last beat of the burst.
//
//               Bus payloads are flat packed vectors, MSB first:
//                 req  [114:0] = {valid, is_write, size[2:0], addr[31:0],
//                                 strobe[7:0], data[63:0], len[3:0],
//                                 burst[1:0]}
//                 resp [65:0]  = {ready, last, data[63:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arbiter #(
    parameter int FIX_PRIORITY = 0,   // 0: round-robin, 1: data port wins ties
    parameter int RESET_LAST_D = 1,   // last-granted pointer after reset
    localparam int c_REQ_W     = 115,
    localparam int c_RESP_W    = 66
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_REQ_W-1:0]  ireq,
    output logic [c_RESP_W-1:0] iresp,
    input  logic [c_REQ_W-1:0]  dreq,
    output logic [c_RESP_W-1:0] dresp,
    output logic [c_REQ_W-1:0]  oreq,
    input  logic [c_RESP_W-1:0] oresp
);

    localparam int c_REQ_VALID  = c_REQ_W - 1;
    localparam int c_RESP_READY = c_RESP_W - 1;
    localparam int c_RESP_LAST  = c_RESP_W - 2;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_grant;          // 0 = instruction port, 1 = data port
    logic       w_grant_nxt;
    logic       r_last_grant;     // master whose burst finished most recently
    logic       w_last_grant_nxt;

    logic       w_ivalid;
    logic       w_dvalid;
    logic       w_done;
    logic       w_tie_winner;

    assign w_ivalid = ireq[c_REQ_VALID];
    assign w_dvalid = dreq[c_REQ_VALID];
    assign w_done   = oresp[c_RESP_READY] & oresp[c_RESP_LAST];

    // On a tie, fixed priority always picks D; round-robin picks whoever
    // was not served last.
    assign w_tie_winner = (FIX_PRIORITY != 0) ? 1'b1 : ~r_last_grant;

    // State, grant and last-grant registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= (RESET_LAST_D != 0);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Arbitrate in IDLE; hold the grant in BUSY until the last beat
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_IDLE: begin
                // Slave responses seen while idle are spurious and ignored.
                if (w_ivalid || w_dvalid) begin
                    w_state_nxt = c_BUSY;
                    if (w_ivalid && w_dvalid) begin
                        w_grant_nxt = w_tie_winner;
                    end else begin
                        w_grant_nxt = w_dvalid;
                    end
                end
            end
            c_BUSY: begin
                // A granted master dropping valid does not release the bus;
                // only the accepted last beat does.
                if (w_done) begin
                    w_state_nxt      = c_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Route the granted request out and the slave response back while BUSY;
    // everything is zero in IDLE and during reset
    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        if ((r_state == c_BUSY) && !reset) begin
            if (r_grant) begin
                oreq  = dreq;
                dresp = oresp;
            end else begin
                oreq  = ireq;
                iresp = oresp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Randomized self-checking bench for cbus_arbiter. Instance 0 is
//               round-robin, instance 1 is fixed priority. Cache masters and
//               the memory slave are modelled at transaction level; expected
//               outputs come from a burst-ownership model of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;

    localparam int c_REQ_W  = 115;
    localparam int c_RESP_W = 66;
    localparam int c_NCYC   = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [c_REQ_W-1:0]  ireq  [2];
    logic [c_REQ_W-1:0]  dreq  [2];
    logic [c_REQ_W-1:0]  oreq  [2];
    logic [c_RESP_W-1:0] iresp [2];
    logic [c_RESP_W-1:0] dresp [2];
    logic [c_RESP_W-1:0] oresp [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cbus_arbiter #(
            .FIX_PRIORITY (g),
            .RESET_LAST_D (1)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .ireq  (ireq[g]),
            .iresp (iresp[g]),
            .dreq  (dreq[g]),
            .dresp (dresp[g]),
            .oreq  (oreq[g]),
            .oresp (oresp[g])
        );
    end

    // Master state, indexed [instance][master], master 0 = I, 1 = D
    bit          mv    [2][2];
    bit          mw    [2][2];
    logic [2:0]  msz   [2][2];
    logic [31:0] madr  [2][2];
    logic [7:0]  mstb  [2][2];
    logic [63:0] mbase [2][2];
    int          mbeat [2][2];
    logic [3:0]  mlen  [2][2];
    logic [1:0]  mbst  [2][2];

    // Bus model: which master currently owns the slave (-1 = nobody),
    // who finished last, and the slave's beat counter
    int own   [2];
    int lastg [2];
    int sbeat [2];

    int n_vec = 0;
    int n_err = 0;

    logic                rdy;
    logic                lst;
    logic [c_REQ_W-1:0]  eo;
    logic [c_RESP_W-1:0] ei;
    logic [c_RESP_W-1:0] ed;
    string               nm;

    task automatic chk(input string tag, input logic [c_REQ_W-1:0] act,
                       input logic [c_REQ_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [c_REQ_W-1:0] pack_req(input int m, input int k);
        logic [63:0] d;
        d = mbase[m][k] + 64'(mbeat[m][k]);
        return {mv[m][k], mw[m][k], msz[m][k], madr[m][k], mstb[m][k], d,
                mlen[m][k], mbst[m][k]};
    endfunction

    task automatic new_burst(input int m, input int k);
        int sel;
        mv[m][k]    = 1'b1;
        mw[m][k]    = (k == 1) ? 1'($urandom % 2) : 1'b0;
        msz[m][k]   = 3'd3;
        madr[m][k]  = 32'h8000_0000 | ($urandom & 32'h0000_FFC0);
        mstb[m][k]  = mw[m][k] ? 8'hFF : 8'($urandom);
        mbase[m][k] = {32'hDEAD_BEEF, $urandom};
        mbeat[m][k] = 0;
        sel = int'($urandom % 4);
        mlen[m][k]  = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd15 : 4'($urandom);
        mbst[m][k]  = 2'b01;
    endtask

    initial begin
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            own[m]   = -1;
            lastg[m] = 1;
            sbeat[m] = 0;
            oresp[m] = '0;
            for (int k = 0; k < 2; k++) begin
                mv[m][k] = 1'b0;
                new_burst(m, k);
                mv[m][k] = 1'b0;
            end
            ireq[m] = pack_req(m, 0);
            dreq[m] = pack_req(m, 1);
        end

        for (int cyc = 0; cyc < c_NCYC; cyc++) begin
            @(negedge clk);
            reset = (cyc < 3) || ($urandom_range(0, 299) == 0);

            // Drive masters and slave for this cycle
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!mv[m][k] && ($urandom % 3 != 0)) new_burst(m, k);
                end
                ireq[m] = pack_req(m, 0);
                dreq[m] = pack_req(m, 1);
                if (own[m] >= 0) begin
                    rdy = ($urandom % 4) != 0;
                    lst = rdy && (sbeat[m] == int'(mlen[m][own[m]]));
                end else begin
                    // Idle slave occasionally emits spurious ready/last
                    rdy = ($urandom % 6) == 0;
                    lst = ($urandom % 6) == 0;
                end
                oresp[m] = {rdy, lst, $urandom, $urandom};
            end

            #1;

            // Compare against the ownership model
            for (int m = 0; m < 2; m++) begin
                eo = '0;
                ei = '0;
                ed = '0;
                if (!reset && own[m] >= 0) begin
                    eo = pack_req(m, own[m]);
                    if (own[m] == 0) ei = oresp[m];
                    else             ed = oresp[m];
                end
                nm = (m == 0) ? "rr" : "fp";
                chk({nm, " oreq"},  oreq[m],  eo);
                chk({nm, " iresp"}, iresp[m], c_REQ_W'(ei));
                chk({nm, " dresp"}, dresp[m], c_REQ_W'(ed));
            end

            // Advance the model to the next cycle
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    own[m]   = -1;
                    lastg[m] = 1;
                    sbeat[m] = 0;
                    mbeat[m][0] = 0;
                    mbeat[m][1] = 0;
                end else if (own[m] < 0) begin
                    if (mv[m][0] && mv[m][1]) begin
                        // Fixed priority favours D; round-robin favours the
                        // master that did not finish most recently.
                        own[m] = (m == 1) ? 1 : (1 - lastg[m]);
                    end else if (mv[m][0]) begin
                        own[m] = 0;
                    end else if (mv[m][1]) begin
                        own[m] = 1;
                    end
                end else if (oresp[m][c_RESP_W-1]) begin
                    mbeat[m][own[m]]++;
                    sbeat[m]++;
                    if (oresp[m][c_RESP_W-2]) begin
                        mv[m][own[m]] = 1'b0;
                        sbeat[m] = 0;
                        lastg[m] = own[m];
                        own[m]   = -1;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
